spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder with a Wishbone host port: the device end of the bus driven by the SPI master core.
//  SPI mode 3 only (SCLK idles high, data changes on falling edge, sampled on rising edge), MSB first, 8-bit frames.
//  Pins are oversampled on the system clock. One TX holding register and one RX holding register.
//  Status flags and an optional interrupt let a local CPU service transfers.
// PARAMETERS
//  SYNC_STAGES  2      flops in each pin synchronizer (spi_sclk_i, spi_mosi_i, spi_ss_ni); must be >= 2
//  IDLE_TX      8'hFF  byte shifted out when the TX holding register is empty (underrun)
// PORTS
//  wb_clk_i       in   1   system clock; frequency >= 8x SCLK
//  wb_rst_ni      in   1   asynchronous, active-low reset
//  wb_adr_i       in   1   register select: 0=DATA, 1=CTRL/STATUS
//  wb_dat_i       in   16  write data
//  wb_dat_o       out  16  read data, registered
//  wb_we_i        in   1   write enable
//  wb_sel_i       in   2   byte lane selects
//  wb_stb_i       in   1   strobe
//  wb_cyc_i       in   1   cycle
//  wb_ack_o       out  1   single-cycle acknowledge
//  irq_o          out  1   interrupt, registered
//  spi_sclk_i     in   1   serial clock from master
//  spi_mosi_i     in   1   master-out data
//  spi_ss_ni      in   1   slave select, active low
//  spi_miso_o     out  1   slave-out data
//  spi_miso_oe_o  out  1   MISO output enable (high while selected)
// BEHAVIOUR
//  Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, spi_miso_o=1, spi_miso_oe_o=0.
//   Reset also sets: synchronizers SCLK=1 SS=1; tx_empty=1; rx_full=0; ovr=0; udr=0; ien=0; bit_cnt=0.
//  Wishbone access: acc = stb & cyc & !wb_ack_o. wb_ack_o <= acc. Every side effect happens in the acc cycle.
//   wb_dat_o is registered in the same cycle, so ack and data appear together.
//  DATA write, sel[0]: txbuf <= dat[7:0], tx_empty <= 0. A write while full overwrites txbuf and raises no flag.
//  DATA read: wb_dat_o = {8'h00, rxbuf}. If sel[0] is set, rx_full is cleared.
//  CTRL write, sel[0]: ien_rx <= d[0], ien_tx <= d[1]. d[2]=1 clears ovr and udr (write-1-to-clear).
//  STATUS read: {6'b0, ien_tx, ien_rx, 3'b0, busy, udr, ovr, tx_empty, rx_full}. busy = SS synchronized low.
//  Edge detect on the synchronized signals: ss_fall, ss_rise, sck_fall, sck_rise. SCLK edges are ignored while SS is high.
//  ss_fall:
//   - bit_cnt <= 0.
//   - shtx <= txbuf and tx_empty <= 1; if tx_empty was already 1, shtx <= IDLE_TX and udr <= 1.
//   - spi_miso_oe_o <= 1.
//  sck_fall: spi_miso_o <= shtx[7]; shtx <= {shtx[6:0], 1'b1}.
//  sck_rise: shrx <= {shrx[6:0], mosi_s}; bit_cnt <= bit_cnt+1 (3 bits, wraps 7->0).
//  Byte completion (sck_rise with bit_cnt==7):
//   - If rx_full is 0, or is cleared in this same cycle: rxbuf <= completed byte, rx_full <= 1.
//   - Otherwise ovr <= 1, and the new byte is discarded (rxbuf keeps the old byte).
//   - shtx reloads by the same rule as ss_fall, so back-to-back frames under one SS assertion work.
//  Same-cycle TX write and reload: the reload sees the pre-write tx_empty; the write then lands in txbuf.
//  ss_rise (including mid-byte):
//   - Partial byte is discarded; bit_cnt <= 0.
//   - spi_miso_oe_o <= 0, spi_miso_o <= 1.
//   - tx_empty/txbuf are untouched.
//  Latency: rx_full rises SYNC_STAGES+1 clocks after the 8th SCLK rising edge at the pin.
//   MISO updates SYNC_STAGES+1 clocks after the SCLK falling edge.
//  irq_o <= (ien_rx & rx_full) | (ien_tx & tx_empty).
//  Async reset asserted mid-frame: all state returns to reset values immediately; MISO is released.
// TESTING
//  1. Reset pulse while selected and clocked -> miso_oe=0, miso=1, STATUS reads 16'h0002, irq_o=0.
//  2. Write DATA=8'hA5, CTRL=3; master sends 8'h3C ->
//     miso bits 1,0,1,0,0,1,0,1; DATA read = 16'h003C; rx_full=1; irq_o=1; rx_full=0 after the read.
//  3. No TX loaded; master sends one byte -> miso 8'hFF, udr=1. CTRL write 16'h0004 -> udr=0.
//  4. Two frames 8'h11, 8'h22 with no read -> DATA = 8'h11, ovr=1.
//     Read at the exact cycle of the 2nd completion instead -> rxbuf=8'h22, ovr=0.
//  5. SS released after 5 bits, then full frame 8'h5A -> no rx_full after the partial; DATA = 8'h5A.
//  6. TX=8'h81, 8'h7E loaded between frames under one SS assertion -> miso shows 8'h81 then 8'h7E, no udr.

Source files
------------

// File: rtl/spi_slave_if.sv
// Wishbone host-port bundle for the SPI responder.
// The master modport is the local CPU side; the slave modport is the responder.
interface spi_slave_if;
  logic        wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 responder (MSB first, 8-bit frames) with oversampled pins,
// single TX/RX holding registers and a Wishbone register port. SYNC_STAGES must be >= 2.
module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_ni,
  spi_slave_if.slave wb,
  output logic     irq_o,
  input  logic     spi_sclk_i,
  input  logic     spi_mosi_i,
  input  logic     spi_ss_ni,
  output logic     spi_miso_o,
  output logic     spi_miso_oe_o
);

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_p0, ss_p0, mosi_p0;
  logic       sck_p1, ss_p1;
  logic       tx_empty, rx_full, ovr, udr, ien_rx, ien_tx;
  logic [2:0] bit_cnt;
  logic [7:0] txbuf, rxbuf, shtx, shrx;

  logic       acc, wr_data, rd_clr, wr_ctrl;
  logic       act, ss_fall, ss_rise, sck_rise, sck_fall;
  logic       byte_done, reload, rx_accept;
  logic [7:0] rx_byte;
  logic [15:0] status;
  logic       unused_ok;

  // Pin synchronizers (stage _p0 = synchronized, _p1 = one clock older for edge detect)
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sck_sync <= '1;
      ss_sync  <= '1;
      sck_p1   <= 1'b1;
      ss_p1    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sclk_i};
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss_ni};
      sck_p1   <= sck_p0;
      ss_p1    <= ss_p0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end

  assign sck_p0  = sck_sync[SYNC_STAGES-1];
  assign ss_p0   = ss_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

  // SCLK edges count only when selected in both this and the previous sample,
  // so an edge coinciding with SS falling cannot race the frame start.
  assign act      = ~ss_p0 & ~ss_p1;
  assign ss_fall  = ~ss_p0 &  ss_p1;
  assign ss_rise  =  ss_p0 & ~ss_p1;
  assign sck_rise = act &  sck_p0 & ~sck_p1;
  assign sck_fall = act & ~sck_p0 &  sck_p1;

  assign acc     = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr_data = acc &  wb.wb_we_i & ~wb.wb_adr_i & wb.wb_sel_i[0];
  assign rd_clr  = acc & ~wb.wb_we_i & ~wb.wb_adr_i & wb.wb_sel_i[0];
  assign wr_ctrl = acc &  wb.wb_we_i &  wb.wb_adr_i & wb.wb_sel_i[0];

  assign byte_done = sck_rise & (bit_cnt == 3'd7);
  assign reload    = ss_fall | byte_done;
  assign rx_accept = byte_done & (~rx_full | rd_clr);
  assign rx_byte   = {shrx[6:0], mosi_p0};

  assign status = {6'b0, ien_tx, ien_rx, 3'b0, ~ss_p0, udr, ovr, tx_empty, rx_full};

  assign unused_ok = &{1'b0, wb.wb_dat_i[15:8], wb.wb_sel_i[1]};

  // Datapath registers carry no reset; their contents are qualified by the flags
  always_ff @(posedge wb_clk_i) begin
    if (reload)
      shtx <= tx_empty ? IDLE_TX : txbuf;
    else if (sck_fall)
      shtx <= {shtx[6:0], 1'b1};
    if (wr_data)   txbuf <= wb.wb_dat_i[7:0];
    if (sck_rise)  shrx  <= rx_byte;
    if (rx_accept) rxbuf <= rx_byte;
  end

  // Control, flags, pins and bus responses
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb.wb_ack_o   <= 1'b0;
      wb.wb_dat_o   <= 16'h0000;
      irq_o         <= 1'b0;
      spi_miso_o    <= 1'b1;
      spi_miso_oe_o <= 1'b0;
      tx_empty      <= 1'b1;
      rx_full       <= 1'b0;
      ovr           <= 1'b0;
      udr           <= 1'b0;
      ien_rx        <= 1'b0;
      ien_tx        <= 1'b0;
      bit_cnt       <= 3'd0;
    end else begin
      wb.wb_ack_o <= acc;
      if (acc & ~wb.wb_we_i)
        wb.wb_dat_o <= wb.wb_adr_i ? status : {8'h00, rxbuf};

      if (wr_ctrl) begin
        ien_rx <= wb.wb_dat_i[0];
        ien_tx <= wb.wb_dat_i[1];
        if (wb.wb_dat_i[2]) begin
          ovr <= 1'b0;
          udr <= 1'b0;
        end
      end

      // Later assignments win: a same-cycle read clear yields to a new byte,
      // and a same-cycle TX write lands after the reload consumed the old state.
      if (rd_clr) rx_full <= 1'b0;
      if (reload) begin
        tx_empty <= 1'b1;
        if (tx_empty) udr <= 1'b1;
      end
      if (wr_data) tx_empty <= 1'b0;
      if (byte_done) begin
        if (rx_full & ~rd_clr) ovr     <= 1'b1;
        else                   rx_full <= 1'b1;
      end

      if (ss_fall) begin
        bit_cnt       <= 3'd0;
        spi_miso_oe_o <= 1'b1;
      end else if (ss_rise) begin
        bit_cnt       <= 3'd0;
        spi_miso_oe_o <= 1'b0;
        spi_miso_o    <= 1'b1;
      end else begin
        if (sck_rise) bit_cnt    <= 3'(bit_cnt + 3'd1);
        if (sck_fall) spi_miso_o <= shtx[7];
      end

      irq_o <= (ien_rx & rx_full) | (ien_tx & tx_empty);
    end
  end

endmodule
